// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: combinational decode of the incoming word, captured into a
// single-entry valid/ready register, with illegal detection and handoff counters.

package riscv_pkg;
  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } immediate_type_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_AUIPC = 4'd11
  } alu_op_e;
endpackage

module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = riscv_pkg::XLEN,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          instr_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      pc_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [4:0]           rd_o,
  output logic [XLEN-1:0]      imm_o,
  output logic [2:0]           imm_type_o,
  output logic [3:0]           alu_op_o,
  output logic                 alu_src_imm_o,
  output logic                 reg_write_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic [2:0]           mem_funct3_o,
  output logic                 branch_o,
  output logic                 jump_o,
  output logic                 jalr_o,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] decode_cnt_o,
  output logic [CNT_WIDTH-1:0] illegal_cnt_o
);

  typedef enum logic {EMPTY, FULL} state_e;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    immediate_type_e imm_type;
    alu_op_e         alu_op;
    logic            alu_src_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      mem_funct3;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            illegal;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d, dec_ctrl;
  logic [XLEN-1:0] imm_q, imm_d, pc_q, pc_d;
  logic [CNT_WIDTH-1:0] decode_cnt_q, decode_cnt_d, illegal_cnt_q, illegal_cnt_d;
  logic [31:0] dec_imm32;
  logic        dec_bad;
  logic        accept, handoff;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // alt selects SUB/SRA; callers decide when funct7 is allowed to request it
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

  // Decode the presented word into control fields; illegal words collapse to a bare flag
  always_comb begin
    dec_ctrl  = '0;
    dec_imm32 = '0;
    dec_bad   = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_ctrl.rd          = instr_i[11:7];
        dec_ctrl.imm_type    = IMM_U;
        dec_imm32            = imm_u;
        dec_ctrl.alu_op      = (opcode == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.reg_write   = 1'b1;
      end
      OPC_JAL: begin
        dec_ctrl.rd          = instr_i[11:7];
        dec_ctrl.imm_type    = IMM_J;
        dec_imm32            = imm_j;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.reg_write   = 1'b1;
        dec_ctrl.jump        = 1'b1;
      end
      OPC_JALR: begin
        dec_ctrl.rs1         = instr_i[19:15];
        dec_ctrl.rd          = instr_i[11:7];
        dec_ctrl.imm_type    = IMM_I;
        dec_imm32            = imm_i;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.reg_write   = 1'b1;
        dec_ctrl.jalr        = 1'b1;
        dec_bad              = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec_ctrl.rs1      = instr_i[19:15];
        dec_ctrl.rs2      = instr_i[24:20];
        dec_ctrl.imm_type = IMM_B;
        dec_imm32         = imm_b;
        dec_ctrl.branch   = 1'b1;
        case (funct3)
          3'b000, 3'b001: dec_ctrl.alu_op = ALU_SUB;
          3'b100, 3'b101: dec_ctrl.alu_op = ALU_SLT;
          3'b110, 3'b111: dec_ctrl.alu_op = ALU_SLTU;
          default:        dec_bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_ctrl.rs1         = instr_i[19:15];
        dec_ctrl.rd          = instr_i[11:7];
        dec_ctrl.imm_type    = IMM_I;
        dec_imm32            = imm_i;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.reg_write   = 1'b1;
        dec_ctrl.mem_read    = 1'b1;
        dec_ctrl.mem_funct3  = funct3;
        dec_bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec_ctrl.rs1         = instr_i[19:15];
        dec_ctrl.rs2         = instr_i[24:20];
        dec_ctrl.imm_type    = IMM_S;
        dec_imm32            = imm_s;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.mem_write   = 1'b1;
        dec_ctrl.mem_funct3  = funct3;
        dec_bad              = (funct3 > 3'b010);
      end
      OPC_OP_IMM: begin
        dec_ctrl.rs1         = instr_i[19:15];
        dec_ctrl.rd          = instr_i[11:7];
        dec_ctrl.imm_type    = IMM_I;
        dec_imm32            = imm_i;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.reg_write   = 1'b1;
        // only the shift-right form may use funct7 as an opcode extension
        dec_ctrl.alu_op = alu_from_f3(funct3, (funct3 == F3_SRL_SRA) && (funct7 == F7_ALT));
        if (funct3 == F3_SLL)
          dec_bad = (funct7 != F7_BASE);
        else if (funct3 == F3_SRL_SRA)
          dec_bad = (funct7 != F7_BASE) && (funct7 != F7_ALT);
      end
      OPC_OP: begin
        dec_ctrl.rs1       = instr_i[19:15];
        dec_ctrl.rs2       = instr_i[24:20];
        dec_ctrl.rd        = instr_i[11:7];
        dec_ctrl.imm_type  = IMM_I;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = alu_from_f3(funct3, funct7 == F7_ALT);
        dec_bad = !((funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA))));
      end
      default: dec_bad = 1'b1;
    endcase
    if (instr_i[1:0] != 2'b11)
      dec_bad = 1'b1;
    if (dec_ctrl.rd == 5'd0)
      dec_ctrl.reg_write = 1'b0;
    if (dec_bad) begin
      dec_ctrl         = '0;
      dec_ctrl.illegal = 1'b1;
      dec_imm32        = '0;
    end
  end

  assign accept  = in_valid_i && in_ready_o && !flush_i;
  assign handoff = out_valid_o && out_ready_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  // Next state: flush wins, a fresh accept refills, a consume with no refill drains
  always_comb begin
    state_d = state_q;
    if (flush_i)
      state_d = EMPTY;
    else if (accept)
      state_d = FULL;
    else if ((state_q == FULL) && out_ready_i)
      state_d = EMPTY;
  end

  // Handshake outputs derived from state
  always_comb begin
    out_valid_o = (state_q == FULL);
    in_ready_o  = (state_q != FULL) || out_ready_i;
  end

  // Entry payload is replaced only on accept, so a stalled entry stays stable
  always_comb begin
    ctrl_d = ctrl_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    if (accept) begin
      ctrl_d = dec_ctrl;
      imm_d  = XLEN'($signed(dec_imm32));
      pc_d   = pc_i;
    end
  end

  // Count consumed entries by legality; counters wrap naturally
  always_comb begin
    decode_cnt_d  = decode_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (handoff) begin
      if (ctrl_q.illegal) illegal_cnt_d = illegal_cnt_q + 1'b1;
      else                decode_cnt_d  = decode_cnt_q + 1'b1;
    end
  end

  // Payload and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q        <= '0;
      imm_q         <= '0;
      pc_q          <= '0;
      decode_cnt_q  <= '0;
      illegal_cnt_q <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      imm_q         <= imm_d;
      pc_q          <= pc_d;
      decode_cnt_q  <= decode_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign pc_o          = pc_q;
  assign imm_o         = imm_q;
  assign rs1_o         = ctrl_q.rs1;
  assign rs2_o         = ctrl_q.rs2;
  assign rd_o          = ctrl_q.rd;
  assign imm_type_o    = ctrl_q.imm_type;
  assign alu_op_o      = ctrl_q.alu_op;
  assign alu_src_imm_o = ctrl_q.alu_src_imm;
  assign reg_write_o   = ctrl_q.reg_write;
  assign mem_read_o    = ctrl_q.mem_read;
  assign mem_write_o   = ctrl_q.mem_write;
  assign mem_funct3_o  = ctrl_q.mem_funct3;
  assign branch_o      = ctrl_q.branch;
  assign jump_o        = ctrl_q.jump;
  assign jalr_o        = ctrl_q.jalr;
  assign illegal_o     = ctrl_q.illegal;
  assign decode_cnt_o  = decode_cnt_q;
  assign illegal_cnt_o = illegal_cnt_q;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: directed vector table, handshake corner sequences,
// and random traffic against an instruction-level reference model.
module tb_riscv_decode_stage;
  import riscv_pkg::*;

  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst_ni, in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i;
  logic [31:0] instr_i, pc_i, pc_o, imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [2:0]  imm_type_o, mem_funct3_o;
  logic [3:0]  alu_op_o;
  logic alu_src_imm_o, reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, jalr_o, illegal_o;
  logic [CW-1:0] decode_cnt_o, illegal_cnt_o;

  riscv_decode_stage #(.XLEN(32), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .pc_o(pc_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .imm_o(imm_o), .imm_type_o(imm_type_o), .alu_op_o(alu_op_o), .alu_src_imm_o(alu_src_imm_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_funct3_o(mem_funct3_o), .branch_o(branch_o), .jump_o(jump_o), .jalr_o(jalr_o),
    .illegal_o(illegal_o), .decode_cnt_o(decode_cnt_o), .illegal_cnt_o(illegal_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [2:0]  imm_type;
    logic [3:0]  alu_op;
    logic        alu_src_imm, reg_write, mem_read, mem_write;
    logic [2:0]  mem_funct3;
    logic        branch, jump, jalr, illegal;
  } fields_t;

  typedef struct {
    logic [31:0] instr;
    fields_t     exp;
  } vec_t;

  localparam alu_op_e OPS8 [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  localparam logic [6:0] LEGAL_OPS [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  int errors = 0;
  int checks = 0;

  // reference state: one held entry plus handoff tallies
  bit      m_valid;
  fields_t m_f;
  int      m_dcnt, m_icnt;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic fields_t gather();
    fields_t g;
    g.pc = pc_o; g.rs1 = rs1_o; g.rs2 = rs2_o; g.rd = rd_o; g.imm = imm_o;
    g.imm_type = imm_type_o; g.alu_op = alu_op_o; g.alu_src_imm = alu_src_imm_o;
    g.reg_write = reg_write_o; g.mem_read = mem_read_o; g.mem_write = mem_write_o;
    g.mem_funct3 = mem_funct3_o; g.branch = branch_o; g.jump = jump_o; g.jalr = jalr_o;
    g.illegal = illegal_o;
    return g;
  endfunction

  function automatic fields_t mk(input int r1, r2, rd, input logic [31:0] imm, input logic [2:0] it,
                                 input logic [3:0] alu, input bit src, wr, mr, mw, input int mf3,
                                 input bit br, jp, jr, ill);
    fields_t f;
    f.pc = '0; f.rs1 = 5'(r1); f.rs2 = 5'(r2); f.rd = 5'(rd); f.imm = imm; f.imm_type = it;
    f.alu_op = alu; f.alu_src_imm = src; f.reg_write = wr; f.mem_read = mr; f.mem_write = mw;
    f.mem_funct3 = 3'(mf3); f.branch = br; f.jump = jp; f.jalr = jr; f.illegal = ill;
    return f;
  endfunction

  // Instruction-level model: classify by opcode, compute the immediate arithmetically,
  // then apply the legality rules as a list of exclusions.
  function automatic fields_t ref_decode(input logic [31:0] w);
    fields_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit ok, u1, u2, ud;
    int imm;
    e = '0; op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    ok = 1; u1 = 0; u2 = 0; ud = 0; imm = 0;
    case (op)
      7'h37, 7'h17: begin
        ud = 1; imm = int'(w & 32'hFFFFF000); e.imm_type = IMM_U;
        e.alu_op = (op == 7'h37) ? ALU_LUI : ALU_AUIPC; e.alu_src_imm = 1; e.reg_write = 1;
      end
      7'h6F: begin
        ud = 1; e.imm_type = IMM_J; e.alu_src_imm = 1; e.reg_write = 1; e.jump = 1;
        imm = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2 - (w[31] ? 1048576 : 0);
      end
      7'h67: begin
        u1 = 1; ud = 1; e.imm_type = IMM_I; e.alu_src_imm = 1; e.reg_write = 1; e.jalr = 1;
        imm = int'(w[30:20]) - (w[31] ? 2048 : 0); ok = (f3 == 0);
      end
      7'h63: begin
        u1 = 1; u2 = 1; e.imm_type = IMM_B; e.branch = 1;
        imm = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
        ok = !(f3 == 2 || f3 == 3);
        e.alu_op = (f3 < 2) ? ALU_SUB : (f3 < 6) ? ALU_SLT : ALU_SLTU;
      end
      7'h03: begin
        u1 = 1; ud = 1; e.imm_type = IMM_I; e.alu_src_imm = 1; e.reg_write = 1; e.mem_read = 1;
        e.mem_funct3 = f3; imm = int'(w[30:20]) - (w[31] ? 2048 : 0);
        ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      end
      7'h23: begin
        u1 = 1; u2 = 1; e.imm_type = IMM_S; e.alu_src_imm = 1; e.mem_write = 1; e.mem_funct3 = f3;
        imm = int'({w[30:25], w[11:7]}) - (w[31] ? 2048 : 0); ok = (f3 <= 2);
      end
      7'h13: begin
        u1 = 1; ud = 1; e.imm_type = IMM_I; e.alu_src_imm = 1; e.reg_write = 1;
        imm = int'(w[30:20]) - (w[31] ? 2048 : 0);
        e.alu_op = (f3 == 5 && f7 == 7'h20) ? ALU_SRA : OPS8[f3];
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
      end
      7'h33: begin
        u1 = 1; u2 = 1; ud = 1; e.imm_type = IMM_I; e.reg_write = 1;
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.alu_op = (f7 == 7'h20) ? ((f3 == 0) ? ALU_SUB : ALU_SRA) : OPS8[f3];
      end
      default: ok = 0;
    endcase
    e.imm = imm;
    e.rs1 = u1 ? w[19:15] : 5'd0;
    e.rs2 = u2 ? w[24:20] : 5'd0;
    e.rd  = ud ? w[11:7]  : 5'd0;
    if (e.rd == 0) e.reg_write = 0;
    if (!ok) begin
      e = '0;
      e.illegal = 1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 15);
    if (k < 13) w[6:0] = LEGAL_OPS[$urandom_range(0, 8)];
    if (k >= 9 && k < 13) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  // One clock of traffic: drive after negedge, check ready, advance model, check after edge
  task automatic step(input bit v, input logic [31:0] w, input logic [31:0] pc,
                      input bit ordy, input bit fl);
    bit rdy, hand, acc;
    @(negedge clk);
    in_valid_i = v; instr_i = w; pc_i = pc; out_ready_i = ordy; flush_i = fl;
    #1;
    rdy = !m_valid || ordy;
    check("in_ready", in_ready_o, rdy);
    hand = m_valid && ordy;
    if (hand) begin
      if (m_f.illegal) m_icnt++;
      else             m_dcnt++;
    end
    acc = v && rdy && !fl;
    if (fl) m_valid = 0;
    else if (acc) begin
      m_valid = 1;
      m_f = ref_decode(w);
      m_f.pc = pc;
    end else if (hand) m_valid = 0;
    @(posedge clk);
    #1;
    check("out_valid", out_valid_o, m_valid);
    check("decode_cnt", decode_cnt_o, m_dcnt % (1 << CW));
    check("illegal_cnt", illegal_cnt_o, m_icnt % (1 << CW));
    if (m_valid) check("fields", gather(), m_f);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_ni = 1'b0;
    #1;
    check("rst_valid", out_valid_o, 0);
    check("rst_ready", in_ready_o, 1);
    check("rst_fields", gather(), 0);
    check("rst_cnt", {decode_cnt_o, illegal_cnt_o}, 0);
    m_valid = 0; m_f = '0; m_dcnt = 0; m_icnt = 0;
    @(negedge clk);
    in_valid_i = 0; flush_i = 0; out_ready_i = 0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1);
  end

  vec_t tbl [15];

  initial begin
    int tc0, ti0;
    fields_t e;
    tbl[0]  = '{32'h00500093, mk(0, 0, 1, 32'd5,        IMM_I, ALU_ADD,  1, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{32'h402081B3, mk(1, 2, 3, 32'd0,        IMM_I, ALU_SUB,  0, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{32'h002081B3, mk(1, 2, 3, 32'd0,        IMM_I, ALU_ADD,  0, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{32'hFE208EE3, mk(1, 2, 0, 32'hFFFFFFFC, IMM_B, ALU_SUB,  0, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[4]  = '{32'h00000000, mk(0, 0, 0, 32'd0,        IMM_I, ALU_ADD,  0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[5]  = '{32'h0000F003, mk(0, 0, 0, 32'd0,        IMM_I, ALU_ADD,  0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[6]  = '{32'h123452B7, mk(0, 0, 5, 32'h12345000, IMM_U, ALU_LUI,  1, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[7]  = '{32'h008000EF, mk(0, 0, 1, 32'd8,        IMM_J, ALU_ADD,  1, 1, 0, 0, 0, 0, 1, 0, 0)};
    tbl[8]  = '{32'h0020A423, mk(1, 2, 0, 32'd8,        IMM_S, ALU_ADD,  1, 0, 0, 1, 2, 0, 0, 0, 0)};
    tbl[9]  = '{32'hFFF1A203, mk(3, 0, 4, 32'hFFFFFFFF, IMM_I, ALU_ADD,  1, 1, 1, 0, 2, 0, 0, 0, 0)};
    tbl[10] = '{32'h40335293, mk(6, 0, 5, 32'h00000403, IMM_I, ALU_SRA,  1, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[11] = '{32'h00000013, mk(0, 0, 0, 32'd0,        IMM_I, ALU_ADD,  1, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[12] = '{32'h000110E7, mk(0, 0, 0, 32'd0,        IMM_I, ALU_ADD,  0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[13] = '{32'h4020E1B3, mk(0, 0, 0, 32'd0,        IMM_I, ALU_ADD,  0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[14] = '{32'h004100E7, mk(2, 0, 1, 32'd4,        IMM_I, ALU_ADD,  1, 1, 0, 0, 0, 0, 0, 1, 0)};

    rst_ni = 1'b1; in_valid_i = 0; instr_i = '0; pc_i = '0; out_ready_i = 0; flush_i = 0;
    do_reset();

    // two illegal words handed off: illegal count 0 -> 2, decode count untouched
    step(1, 32'h00000000, 32'h200, 1, 0);
    step(1, 32'h0000F003, 32'h204, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    check("illegal_pair_icnt", illegal_cnt_o, 2);
    check("illegal_pair_dcnt", decode_cnt_o, 0);

    // directed table, back to back with the consumer always ready
    for (int i = 0; i < 15; i++) begin
      step(1, tbl[i].instr, 32'h1000 + 32'(4 * i), 1, 0);
      e = tbl[i].exp;
      e.pc = 32'h1000 + 32'(4 * i);
      check($sformatf("vec%0d", i), gather(), e);
    end
    step(0, 32'h0, 32'h0, 1, 0);

    // consumer stalls three cycles while fetch keeps offering a new word
    step(1, 32'h00500093, 32'h300, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h402081B3, 32'h304, 0, 0);
    check("stall_hold_rd", rd_o, 1);
    check("stall_hold_pc", pc_o, 32'h300);
    step(1, 32'h402081B3, 32'h304, 1, 0);
    check("stall_next_alu", alu_op_o, ALU_SUB);
    step(0, 32'h0, 32'h0, 1, 0);

    // flush while full with a valid input pending: entry and input both dropped
    step(1, 32'hFE208EE3, 32'h400, 1, 0);
    tc0 = m_dcnt; ti0 = m_icnt;
    step(1, 32'h00500093, 32'h404, 0, 1);
    check("flush_empty", out_valid_o, 0);
    check("flush_nocount", decode_cnt_o, tc0 % (1 << CW));
    // flush alongside a same-cycle handoff still counts the handed-off entry
    step(1, 32'h00500093, 32'h408, 1, 0);
    step(1, 32'h0000F003, 32'h40C, 1, 1);
    check("flush_handoff", decode_cnt_o, (tc0 + 1) % (1 << CW));
    check("flush_handoff_i", illegal_cnt_o, ti0 % (1 << CW));

    // random traffic, with an asynchronous reset dropped into the middle
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        step(1, rand_instr(), $urandom, 0, 0);
        do_reset();
      end
      step(($urandom % 4) != 0, rand_instr(), $urandom, ($urandom % 3) != 0, ($urandom % 16) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
